// File: rtl/vsm_instr_queue.sv
// DEPTH-entry {opcode, operand} prefetch queue for the VSM datapath.
// Head opcode appears on ToInstr; head operand is driven onto shared bus B under EnableInstrReg.
module vsm_instr_queue #(
    parameter  int OPW   = 4,
    parameter  int ARGW  = 4,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            MainClock,
    input  logic            ClearInstrReg,
    input  logic [OPW-1:0]  Instr,
    input  logic [ARGW-1:0] Data,
    input  logic            LatchInstrReg,
    input  logic            AdvanceInstrReg,
    input  logic            FlushInstrReg,
    input  logic            EnableInstrReg,
    output logic [OPW-1:0]  ToInstr,
    output tri   [ARGW-1:0] B,
    output logic            ValidInstrReg,
    output logic            FullInstrReg,
    output logic [CW-1:0]   CountInstrReg,
    output logic            OverflowInstrReg
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW = OPW + ARGW;

    typedef logic [PW-1:0] ptr_t;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    logic [WW-1:0] mem_q [DEPTH];
    logic [WW-1:0] mem_d [DEPTH];
    ptr_t          rd_q, rd_d;
    ptr_t          wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          full;
    logic          pop_eff;
    logic          push_eff;
    logic [WW-1:0] push_word;
    logic [WW-1:0] head_word;

    always_comb begin
        full       = (count_q == CW'(DEPTH));
        pop_eff    = AdvanceInstrReg && (count_q != '0);
        push_eff   = LatchInstrReg && (!full || pop_eff);
        push_word  = {Instr, Data};
        mem_d      = mem_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (FlushInstrReg) begin
            // A push in the flush cycle restarts the queue with that word as its only entry.
            rd_d = '0;
            if (LatchInstrReg) begin
                mem_d[0] = push_word;
                wr_d     = ptr_inc('0);
                count_d  = CW'(1);
            end else begin
                wr_d    = '0;
                count_d = '0;
            end
        end else begin
            if (push_eff) begin
                mem_d[wr_q] = push_word;
                wr_d        = ptr_inc(wr_q);
            end
            if (pop_eff) begin
                rd_d = ptr_inc(rd_q);
            end
            if (push_eff && !pop_eff) begin
                count_d = count_q + CW'(1);
            end else if (pop_eff && !push_eff) begin
                count_d = count_q - CW'(1);
            end
            if (LatchInstrReg && !push_eff) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge MainClock) begin
        if (ClearInstrReg) begin
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: nothing is visible while count is zero.
    always_ff @(posedge MainClock) begin
        mem_q <= mem_d;
    end

    assign head_word        = mem_q[rd_q];
    assign ValidInstrReg    = (count_q != '0);
    assign FullInstrReg     = full;
    assign CountInstrReg    = count_q;
    assign OverflowInstrReg = overflow_q;
    assign ToInstr          = ValidInstrReg ? head_word[WW-1 -: OPW] : '0;
    assign B                = (EnableInstrReg && ValidInstrReg) ? head_word[ARGW-1:0] : {ARGW{1'bz}};

endmodule

// File: tb/tb_vsm_instr_queue.sv
// Bench for vsm_instr_queue: four instances (DEPTH 4/1/3/5) share one stimulus stream,
// each checked every cycle against its own queue model, plus directed checks on DEPTH=4.
module tb_vsm_instr_queue;

  logic        clk = 1'b0;
  logic        clr, latch, adv, flush, en;
  logic [7:0]  instr;
  logic [15:0] data;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_z(input string name, input bit is_z);
    checks++;
    if (!is_z) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: bus driven, expected Z", name);
    end
  endtask

  // Each instance: DUT, queue reference model, expected-state queue and monitor.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int D   = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 3 : 5;
    localparam int OW  = (g == 0) ? 4 : 8;
    localparam int AW  = (g == 0) ? 4 : 16;
    localparam int CWL = $clog2(D + 1);
    localparam int WW  = OW + AW;
    localparam int EW  = 8 + 1 + WW;

    logic [OW-1:0]  to_instr;
    tri   [AW-1:0]  b;
    logic           valid, full, ovf;
    logic [CWL-1:0] count;

    vsm_instr_queue #(.OPW(OW), .ARGW(AW), .DEPTH(D)) u_dut (
      .MainClock       (clk),
      .ClearInstrReg   (clr),
      .Instr           (instr[OW-1:0]),
      .Data            (data[AW-1:0]),
      .LatchInstrReg   (latch),
      .AdvanceInstrReg (adv),
      .FlushInstrReg   (flush),
      .EnableInstrReg  (en),
      .ToInstr         (to_instr),
      .B               (b),
      .ValidInstrReg   (valid),
      .FullInstrReg    (full),
      .CountInstrReg   (count),
      .OverflowInstrReg(ovf)
    );

    logic [WW-1:0] model_q[$];
    bit            model_ovf = 1'b0;
    logic [EW-1:0] exp_q[$];

    always @(posedge clk) begin : ref_model
      logic [WW-1:0] w;
      logic [WW-1:0] head;
      logic [7:0]    sz;
      bit            was_full;
      bit            popped;
      w = {instr[OW-1:0], data[AW-1:0]};
      if (clr) begin
        model_q.delete();
        model_ovf = 1'b0;
      end else if (flush) begin
        model_q.delete();
        if (latch) model_q.push_back(w);
      end else begin
        was_full = (model_q.size() == D);
        popped   = adv && (model_q.size() > 0);
        if (popped) void'(model_q.pop_front());
        if (latch) begin
          if (!was_full || popped) model_q.push_back(w);
          else model_ovf = 1'b1;
        end
      end
      sz   = 8'(model_q.size());
      head = '0;
      if (model_q.size() > 0) head = model_q[0];
      exp_q.push_back({sz, model_ovf, head});
    end

    always @(negedge clk) begin : monitor
      logic [EW-1:0] e;
      logic [7:0]    e_cnt;
      logic          e_ovf;
      logic [WW-1:0] e_head;
      if (exp_q.size() > 0) begin
        e      = exp_q.pop_front();
        e_cnt  = e[EW-1 -: 8];
        e_ovf  = e[WW];
        e_head = e[WW-1:0];
        check($sformatf("d%0d.count", D), 32'(count), 32'(e_cnt));
        check($sformatf("d%0d.valid", D), 32'(valid), 32'(e_cnt != 0));
        check($sformatf("d%0d.full", D), 32'(full), 32'(e_cnt == D));
        check($sformatf("d%0d.overflow", D), 32'(ovf), 32'(e_ovf));
        check($sformatf("d%0d.to_instr", D), 32'(to_instr), 32'(e_head[WW-1 -: OW]));
        if (en && e_cnt != 0) check($sformatf("d%0d.b", D), 32'(b), 32'(e_head[AW-1:0]));
        else check_z($sformatf("d%0d.b_z", D), b === {AW{1'bz}});
      end
    end
  end

  // One request, sampled on the second rising edge, then requests drop back to idle.
  task automatic cycle(input logic c, input logic l, input logic a, input logic f,
                       input logic [7:0] i, input logic [15:0] d);
    @(posedge clk); #1;
    clr = c; latch = l; adv = a; flush = f; instr = i; data = d;
    @(posedge clk); #1;
    clr = 1'b0; latch = 1'b0; adv = 1'b0; flush = 1'b0;
  endtask

  initial begin
    int phase;
    clr = 1'b1; latch = 1'b0; adv = 1'b0; flush = 1'b0; en = 1'b0;
    instr = '0; data = '0;

    // Reset / idle
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    en = 1'b1;
    @(negedge clk);
    check("rst.count", 32'(g_dut[0].count), 0);
    check("rst.valid", 32'(g_dut[0].valid), 0);
    check("rst.to_instr", 32'(g_dut[0].to_instr), 0);
    check("rst.full", 32'(g_dut[0].full), 0);
    check("rst.overflow", 32'(g_dut[0].ovf), 0);
    check_z("rst.b_z", g_dut[0].b === 4'bzzzz);

    // Fill
    for (int k = 0; k < 4; k++) cycle(0, 1, 0, 0, 8'(k + 1), 16'(10 + k));
    @(negedge clk);
    check("fill.full", 32'(g_dut[0].full), 1);
    check("fill.count", 32'(g_dut[0].count), 4);

    // Overflow: push while full is dropped
    cycle(0, 1, 0, 0, 8'h5, 16'hE);
    @(negedge clk);
    check("ovf.count", 32'(g_dut[0].count), 4);
    check("ovf.head", 32'(g_dut[0].to_instr), 1);
    check("ovf.flag", 32'(g_dut[0].ovf), 1);

    // Drain
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("drain.to_instr", 32'(g_dut[0].to_instr), 32'(k + 1));
      check("drain.b", 32'(g_dut[0].b), 32'(10 + k));
      cycle(0, 0, 1, 0, 0, 0);
    end
    @(negedge clk);
    check("drain.valid", 32'(g_dut[0].valid), 0);
    check("drain.overflow_sticky", 32'(g_dut[0].ovf), 1);
    check_z("drain.b_z", g_dut[0].b === 4'bzzzz);

    // Push+pop while full: head advances, new word lands at the wrapped tail
    for (int k = 0; k < 4; k++) cycle(0, 1, 0, 0, 8'(k + 1), 16'(10 + k));
    cycle(0, 1, 1, 0, 8'h6, 16'hF);
    @(negedge clk);
    check("full_pp.count", 32'(g_dut[0].count), 4);
    check("full_pp.head", 32'(g_dut[0].to_instr), 2);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    @(negedge clk);
    check("full_pp.tail_op", 32'(g_dut[0].to_instr), 6);
    check("full_pp.tail_b", 32'(g_dut[0].b), 32'hF);
    cycle(0, 0, 1, 0, 0, 0);

    // Push+pop while empty: only the push takes effect
    cycle(0, 1, 1, 0, 8'h7, 16'h0);
    @(negedge clk);
    check("empty_pp.count", 32'(g_dut[0].count), 1);
    check("empty_pp.to_instr", 32'(g_dut[0].to_instr), 7);

    // Flush with and without a same-cycle push
    cycle(0, 1, 0, 0, 8'h8, 16'h1);
    cycle(0, 1, 0, 0, 8'h8, 16'h2);
    cycle(0, 1, 1, 1, 8'h9, 16'h3);
    @(negedge clk);
    check("flush_push.count", 32'(g_dut[0].count), 1);
    check("flush_push.to_instr", 32'(g_dut[0].to_instr), 9);
    check("flush_push.b", 32'(g_dut[0].b), 3);
    check("flush_push.overflow", 32'(g_dut[0].ovf), 1);
    cycle(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    check("flush.count", 32'(g_dut[0].count), 0);
    check("flush.valid", 32'(g_dut[0].valid), 0);

    // Clear drops the sticky overflow
    cycle(1, 1, 1, 1, 8'h1, 16'h1);
    @(negedge clk);
    check("clear.overflow", 32'(g_dut[0].ovf), 0);
    check("clear.count", 32'(g_dut[0].count), 0);

    // Random traffic, alternating fill-biased and drain-biased phases
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      phase = (c / 64) % 2;
      latch = ($urandom_range(0, 99) < ((phase != 0) ? 75 : 35));
      adv   = ($urandom_range(0, 99) < ((phase != 0) ? 35 : 75));
      flush = ($urandom_range(0, 31) == 0);
      clr   = ($urandom_range(0, 499) == 0);
      en    = ($urandom_range(0, 3) != 0);
      instr = 8'($urandom);
      data  = 16'($urandom);
    end
    @(posedge clk); #1;
    clr = 1'b0; latch = 1'b0; adv = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
